button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 96 +++++++++
 tb/tb_button_conditioner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Synchronizes and debounces the four raw board inputs of the stopwatch.
// Build option: define PAUSE_TOGGLE_EN to make pse a run/pause toggle; otherwise it is the debounced pause level.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pause,
    input  logic btn_clear,
    input  logic sw_sel,
    input  logic sw_adj,
    output logic pse,
    output logic clr_pulse,
    output logic sel,
    output logic adj
);

    localparam int N_CH     = 4;
    localparam int CH_PAUSE = 0;
    localparam int CH_CLEAR = 1;
    localparam int CH_SEL   = 2;
    localparam int CH_ADJ   = 3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_CH-1:0]  raw;
    logic [N_CH-1:0]  s1;
    logic [N_CH-1:0]  s2;
    logic [N_CH-1:0]  deb;
    logic [N_CH-1:0]  rise;
    logic [CNT_W-1:0] cnt [N_CH];

    assign raw = {sw_adj, sw_sel, btn_clear, btn_pause};

    // A disagreement must persist until cnt hits CNT_MAX; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < N_CH; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        rise = '0;
        for (int i = 0; i < N_CH; i++) begin
            rise[i] = (s2[i] != deb[i]) && s2[i] && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_pulse <= 1'b0;
        end else begin
            clr_pulse <= rise[CH_CLEAR];
        end
    end

`ifdef PAUSE_TOGGLE_EN
    logic pse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pse_q <= 1'b0;
        end else if (rise[CH_PAUSE]) begin
            pse_q <= ~pse_q;
        end
    end

    assign pse = pse_q;
`else
    assign pse = deb[CH_PAUSE];
`endif

    assign sel = deb[CH_SEL];
    assign adj = deb[CH_ADJ];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4; expectations follow the build's PAUSE_TOGGLE_EN setting.
module tb_button_conditioner;

    localparam int DC = 4;

    logic clk;
    logic rst;
    logic btn_pause;
    logic btn_clear;
    logic sw_sel;
    logic sw_adj;
    logic pse;
    logic clr_pulse;
    logic sel;
    logic adj;

    int   n_checks;
    int   n_errors;
    logic pse_exp;

    button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pause (btn_pause),
        .btn_clear (btn_clear),
        .sw_sel    (sw_sel),
        .sw_adj    (sw_adj),
        .pse       (pse),
        .clr_pulse (clr_pulse),
        .sel       (sel),
        .adj       (adj)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs and samples both sit 1 ns after the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        btn_pause = 1'b0;
        btn_clear = 1'b0;
        sw_sel    = 1'b0;
        sw_adj    = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    function automatic logic press_val(input logic cur);
`ifdef PAUSE_TOGGLE_EN
        return ~cur;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic release_val(input logic cur);
`ifdef PAUSE_TOGGLE_EN
        return cur;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        btn_pause = 1'b1;
        btn_clear = 1'b1;
        sw_sel    = 1'b1;
        sw_adj    = 1'b1;

        // Reset held with every raw input high.
        tick(3);
        chk("reset_pse", pse, 1'b0);
        chk("reset_clr", clr_pulse, 1'b0);
        chk("reset_sel", sel, 1'b0);
        chk("reset_adj", adj, 1'b0);
        rst = 1'b0;
        tick(5);
        chk("post_reset_sel_e5", sel, 1'b0);
        chk("post_reset_adj_e5", adj, 1'b0);
        chk("post_reset_pse_e5", pse, 1'b0);
        tick(1);
        chk("post_reset_sel_e6", sel, 1'b1);
        chk("post_reset_adj_e6", adj, 1'b1);
        chk("post_reset_pse_e6", pse, 1'b1);
        chk("post_reset_clr_e6", clr_pulse, 1'b1);
        tick(1);
        chk("post_reset_clr_e7", clr_pulse, 1'b0);

        // Bounce rejection: 3-cycle pulse, 1 low, then hold.
        do_reset();
        pse_exp   = 1'b0;
        btn_pause = 1'b1;
        tick(3);
        btn_pause = 1'b0;
        tick(1);
        chk("bounce_short_pse", pse, 1'b0);
        btn_pause = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk("bounce_wait_pse", pse, 1'b0);
        end
        tick(1);
        pse_exp = press_val(pse_exp);
        chk("bounce_accept_pse", pse, pse_exp);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("bounce_hold_pse", pse, pse_exp);
        end
        btn_pause = 1'b0;
        tick(10);
        pse_exp = release_val(pse_exp);
        chk("bounce_release_pse", pse, pse_exp);

        // Toggle sequence from a fresh reset.
        do_reset();
        pse_exp = 1'b0;
        for (int r = 0; r < 3; r++) begin
            btn_pause = 1'b1;
            tick(10);
            pse_exp = press_val(pse_exp);
            chk("toggle_press_pse", pse, pse_exp);
            btn_pause = 1'b0;
            tick(10);
            pse_exp = release_val(pse_exp);
            chk("toggle_release_pse", pse, pse_exp);
        end

        // Clear held for 30 cycles gives one pulse on edge 6 and leaves pse alone.
        btn_clear = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            chk("clear_hold_clr", clr_pulse, (i == 6) ? 1'b1 : 1'b0);
            chk("clear_hold_pse", pse, pse_exp);
        end
        btn_clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("clear_release_clr", clr_pulse, 1'b0);
        end

        // Simultaneous pause, clear and select.
        btn_pause = 1'b1;
        btn_clear = 1'b1;
        sw_sel    = 1'b1;
        tick(5);
        chk("simul_e5_pse", pse, pse_exp);
        chk("simul_e5_clr", clr_pulse, 1'b0);
        chk("simul_e5_sel", sel, 1'b0);
        tick(1);
        pse_exp = press_val(pse_exp);
        chk("simul_e6_pse", pse, pse_exp);
        chk("simul_e6_clr", clr_pulse, 1'b1);
        chk("simul_e6_sel", sel, 1'b1);
        tick(1);
        chk("simul_e7_clr", clr_pulse, 1'b0);
        chk("simul_e7_pse", pse, pse_exp);
        btn_pause = 1'b0;
        btn_clear = 1'b0;
        sw_sel    = 1'b0;
        tick(10);
        pse_exp = release_val(pse_exp);
        chk("simul_release_pse", pse, pse_exp);
        chk("simul_release_sel", sel, 1'b0);

        // Reset in the middle of an adjust debounce discards the partial count.
        sw_adj = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("midreset_adj", adj, 1'b0);
        chk("midreset_pse", pse, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk("midreset_wait_adj", adj, 1'b0);
        end
        tick(1);
        chk("midreset_accept_adj", adj, 1'b1);
        sw_adj = 1'b0;
        tick(6);
        chk("midreset_release_adj", adj, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
